// File: rtl/adc_trigger.sv
// ADC threshold trigger: a capture/abs/metric pipeline feeding a rising-crossing
// FSM that emits a fixed-length AXI4-Stream burst followed by a holdoff period.
module adc_trigger #(
  parameter int ADC_DATA_WIDTH = 14,
  parameter int POST_SAMPLES   = 1024,
  parameter int HOLDOFF_CYCLES = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  output logic        adc_csn,
  input  logic [15:0] adc_dat_a,
  input  logic [15:0] adc_dat_b,
  input  logic [1:0]  mode,
  input  logic [15:0] trigger_level,
  input  logic        arm,
  output logic        triggered,
  output logic        overrun,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tlast
);

  localparam int          W         = ADC_DATA_WIDTH;
  localparam logic [15:0] LAST_BEAT = 16'(POST_SAMPLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLDOFF} state_t;

  state_t      state;
  logic [W-1:0] smp_a, smp_b;
  logic [W-1:0] abs_a, abs_b;
  logic [W-1:0] abs_a_c, abs_b_c, max_c;
  logic [W:0]   sum_c;
  logic [15:0]  metric, metric_prev, metric_c;
  logic [15:0]  beat_cnt, beat_next, hold_cnt;
  logic         crossing, accepted;
  logic         unused_lsbs;

  assign adc_csn     = 1'b1;
  assign unused_lsbs = ^{adc_dat_a[15-W:0], adc_dat_b[15-W:0]};

  // Two's-complement negate in W bits: the most negative code maps to 2^(W-1).
  always_comb begin
    abs_a_c  = smp_a[W-1] ? (~smp_a) + W'(1) : smp_a;
    abs_b_c  = smp_b[W-1] ? (~smp_b) + W'(1) : smp_b;
    sum_c    = {1'b0, abs_a} + {1'b0, abs_b};
    max_c    = (abs_a >= abs_b) ? abs_a : abs_b;
    metric_c = '0;
    case (mode)
      2'b00:   metric_c = 16'(sum_c);
      2'b01:   metric_c = 16'(max_c);
      2'b10:   metric_c = 16'(abs_a);
      default: metric_c = 16'(abs_b);
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      smp_a       <= '0;
      smp_b       <= '0;
      abs_a       <= '0;
      abs_b       <= '0;
      metric      <= '0;
      metric_prev <= '0;
    end else begin
      smp_a       <= adc_dat_a[15 -: W];
      smp_b       <= adc_dat_b[15 -: W];
      abs_a       <= abs_a_c;
      abs_b       <= abs_b_c;
      metric      <= metric_c;
      metric_prev <= metric;
    end
  end

  assign crossing  = (metric > trigger_level) && (metric_prev <= trigger_level);
  assign accepted  = m_axis_tvalid && m_axis_tready;
  assign beat_next = beat_cnt + 16'd1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      hold_cnt      <= '0;
      triggered     <= 1'b0;
      overrun       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state   <= ARMED;
            overrun <= 1'b0;
          end
        end
        ARMED: begin
          if (!arm) begin
            state <= IDLE;
          end else if (crossing) begin
            state         <= CAPTURE;
            triggered     <= 1'b1;
            beat_cnt      <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= metric;
            m_axis_tlast  <= (LAST_BEAT == '0);
          end
        end
        CAPTURE: begin
          // A new metric sample arrives every cycle; it is kept only if the
          // output register frees up in the same cycle, otherwise it is lost.
          if (accepted && m_axis_tlast) begin
            state         <= HOLDOFF;
            triggered     <= 1'b0;
            hold_cnt      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end else if (accepted) begin
            beat_cnt     <= beat_next;
            m_axis_tdata <= metric;
            m_axis_tlast <= (beat_next == LAST_BEAT);
          end else if (!m_axis_tvalid) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= metric;
            m_axis_tlast  <= (beat_cnt == LAST_BEAT);
          end else begin
            overrun <= 1'b1;
          end
        end
        HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= arm ? ARMED : IDLE;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_trigger.sv
// Self-checking bench for adc_trigger: directed scenarios plus a randomized run,
// all compared against a sample-level behavioural model of the trigger.
module tb_adc_trigger;
  localparam int W    = 14;
  localparam int POST = 4;
  localparam int HOLD = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        adc_csn;
  logic [15:0] adc_dat_a = '0;
  logic [15:0] adc_dat_b = '0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] trigger_level = '0;
  logic        arm = 1'b0;
  logic        triggered, overrun;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast;

  int passed = 0;
  int total  = 0;

  always #5 aclk = ~aclk;

  adc_trigger #(
    .ADC_DATA_WIDTH(W),
    .POST_SAMPLES(POST),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .adc_csn(adc_csn),
    .adc_dat_a(adc_dat_a),
    .adc_dat_b(adc_dat_b),
    .mode(mode),
    .trigger_level(trigger_level),
    .arm(arm),
    .triggered(triggered),
    .overrun(overrun),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast)
  );

  // Behavioural model: metric history as a plain delay line, trigger as flags/counts.
  bit          m_armed, m_burst, m_v, m_l, m_ovr;
  int          m_hold, m_sent, m_d, m_cur, m_prev;
  logic [15:0] p1a, p1b, p2a, p2b;

  function automatic int abs_of(input logic [15:0] x);
    logic signed [W-1:0] s;
    int v;
    s = x[15 -: W];
    v = int'(s);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int metric_of(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b);
    int xa, xb, r;
    xa = abs_of(a);
    xb = abs_of(b);
    case (md)
      2'd0:    r = xa + xb;
      2'd1:    r = (xa > xb) ? xa : xb;
      2'd2:    r = xa;
      default: r = xb;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    int nxt;
    if (!aresetn) begin
      m_armed = 0; m_burst = 0; m_v = 0; m_l = 0; m_ovr = 0;
      m_hold = 0; m_sent = 0; m_d = 0; m_cur = 0; m_prev = 0;
      p1a = '0; p1b = '0; p2a = '0; p2b = '0;
    end else begin
      if (m_burst) begin
        if (m_v && m_axis_tready) begin
          if (m_sent == POST - 1) begin
            m_burst = 0; m_hold = HOLD; m_v = 0; m_l = 0;
          end else begin
            m_sent++; m_d = m_cur; m_l = (m_sent == POST - 1);
          end
        end else begin
          m_ovr = 1;
        end
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_armed = arm;
      end else if (m_armed) begin
        if (!arm) m_armed = 0;
        else if (m_cur > int'(trigger_level) && m_prev <= int'(trigger_level)) begin
          m_burst = 1; m_sent = 0; m_v = 1; m_d = m_cur; m_l = 0;
        end
      end else if (arm) begin
        m_armed = 1; m_ovr = 0;
      end
      nxt = metric_of(mode, p2a, p2b);
      m_prev = m_cur; m_cur = nxt;
      p2a = p1a; p2b = p1b;
      p1a = adc_dat_a; p1b = adc_dat_b;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    arm = 1'b0; m_axis_tready = 1'b1;
    adc_dat_a = '0; adc_dat_b = '0;
    repeat (HOLD + POST + 10) tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; arm = 1'b0;
    repeat (3) tick();
    total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); else passed++;
    total++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast got=%b want=0", m_axis_tlast); else passed++;
    total++; if (m_axis_tdata !== 16'h0) $display("FAIL reset_tdata got=%h want=0000", m_axis_tdata); else passed++;
    total++; if (triggered !== 1'b0) $display("FAIL reset_triggered got=%b want=0", triggered); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b want=0", overrun); else passed++;
    total++; if (adc_csn !== 1'b1) $display("FAIL adc_csn got=%b want=1", adc_csn); else passed++;
    aresetn = 1'b1;
  endtask

  task automatic test_metric();
    int n;
    // sum of abs values, three-stage latency plus one edge to trigger
    settle();
    mode = 2'b00; trigger_level = 16'd5; arm = 1'b1;
    repeat (5) tick();
    adc_dat_a = 16'hFFFC; adc_dat_b = 16'h0028;
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); n++; if (m_axis_tvalid) break; end
    total++; if (n !== 4) $display("FAIL metric_latency got=%0d want=4", n); else passed++;
    total++; if (m_axis_tdata !== 16'd11) $display("FAIL metric_sum got=%0d want=11", m_axis_tdata); else passed++;
    total++; if (m_axis_tdata !== 16'(m_d)) $display("FAIL metric_sum_model got=%0d want=%0d", m_axis_tdata, m_d); else passed++;
    // most-negative input; mode change acts on the final stage only
    settle();
    mode = 2'b11; trigger_level = 16'd100; adc_dat_a = 16'h8000; adc_dat_b = '0; arm = 1'b1;
    repeat (6) tick();
    mode = 2'b10;
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); n++; if (m_axis_tvalid) break; end
    total++; if (n !== 2) $display("FAIL mode_change_latency got=%0d want=2", n); else passed++;
    total++; if (m_axis_tdata !== 16'h2000) $display("FAIL abs_most_negative got=%h want=2000", m_axis_tdata); else passed++;
    settle();
    mode = 2'b00; arm = 1'b1;
    repeat (4) tick();
    adc_dat_a = 16'h8000; adc_dat_b = 16'h8000;
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); n++; if (m_axis_tvalid) break; end
    total++; if (n !== 4) $display("FAIL sum_neg_latency got=%0d want=4", n); else passed++;
    total++; if (m_axis_tdata !== 16'h4000) $display("FAIL sum_most_negative got=%h want=4000", m_axis_tdata); else passed++;
  endtask

  task automatic setup_50();
    settle();
    mode = 2'b10; trigger_level = 16'd100; adc_dat_a = 16'd200;
    repeat (5) tick();
    arm = 1'b1;
    repeat (3) tick();
    adc_dat_a = 16'd800;
  endtask

  task automatic test_burst();
    int beats;
    setup_50();
    beats = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        total++; if (m_axis_tdata !== 16'd200) $display("FAIL burst_data beat=%0d got=%0d want=200", beats, m_axis_tdata); else passed++;
        total++; if (m_axis_tlast !== (beats == POST)) $display("FAIL burst_tlast beat=%0d got=%b want=%b", beats, m_axis_tlast, beats == POST); else passed++;
      end
      tick();
    end
    total++; if (beats !== POST) $display("FAIL burst_count got=%0d want=%0d", beats, POST); else passed++;
    total++; if (triggered !== 1'b0) $display("FAIL burst_triggered_after got=%b want=0", triggered); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL burst_overrun got=%b want=0", overrun); else passed++;
  endtask

  task automatic test_backpressure();
    int beats, stall;
    logic [15:0] held;
    setup_50();
    beats = 0; stall = 0; held = '0;
    for (int i = 0; i < 40; i++) begin
      if (m_axis_tvalid) begin
        if (beats == 1 && stall < 3) begin
          m_axis_tready = 1'b0;
          if (stall == 0) held = m_axis_tdata;
          else begin
            total++; if (m_axis_tdata !== held) $display("FAIL stall_stable got=%0d want=%0d", m_axis_tdata, held); else passed++;
          end
          stall++;
        end else begin
          m_axis_tready = 1'b1;
          beats++;
          total++; if (m_axis_tdata !== 16'(m_d) || m_axis_tdata !== 16'd200) $display("FAIL bp_data beat=%0d got=%0d want=200", beats, m_axis_tdata); else passed++;
          total++; if (m_axis_tlast !== (beats == POST)) $display("FAIL bp_tlast beat=%0d got=%b want=%b", beats, m_axis_tlast, beats == POST); else passed++;
        end
      end
      tick();
    end
    m_axis_tready = 1'b1;
    total++; if (beats !== POST) $display("FAIL bp_count got=%0d want=%0d", beats, POST); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL bp_overrun got=%b want=1", overrun); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int beats, n;
    bit stalled;
    setup_50();
    beats = 0; stalled = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_axis_tvalid) begin
        if (beats == 1 && !stalled) begin
          m_axis_tready = 1'b0; stalled = 1;
        end else begin
          m_axis_tready = 1'b1;
          if (beats == 2) break;
          beats++;
        end
      end
      tick();
    end
    total++; if (overrun !== 1'b1) $display("FAIL mid_overrun_before got=%b want=1", overrun); else passed++;
    aresetn = 1'b0;
    tick();
    total++; if (m_axis_tvalid !== 1'b0) $display("FAIL mid_reset_tvalid got=%b want=0", m_axis_tvalid); else passed++;
    total++; if (triggered !== 1'b0) $display("FAIL mid_reset_triggered got=%b want=0", triggered); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL mid_reset_overrun got=%b want=0", overrun); else passed++;
    total++; if (m_axis_tdata !== 16'h0) $display("FAIL mid_reset_tdata got=%h want=0000", m_axis_tdata); else passed++;
    aresetn = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); n++; if (m_axis_tvalid) break; end
    total++; if (n !== 4) $display("FAIL first_capture_after_reset got=%0d want=4", n); else passed++;
  endtask

  task automatic test_armed_above();
    int cnt, n;
    bit seen;
    settle();
    mode = 2'b10; trigger_level = 16'd100; adc_dat_a = 16'd800;
    repeat (6) tick();
    arm = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (m_axis_tvalid) cnt++; end
    adc_dat_a = 16'd200;
    for (int i = 0; i < 6; i++) begin tick(); if (m_axis_tvalid) cnt++; end
    total++; if (cnt !== 0) $display("FAIL above_on_arm valid_cycles got=%0d want=0", cnt); else passed++;
    adc_dat_a = 16'd800;
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); n++; if (m_axis_tvalid) break; end
    total++; if (n !== 4) $display("FAIL retrigger_after_drop got=%0d want=4", n); else passed++;
    // unsigned full-width level boundaries around a 0x4000 metric
    settle();
    mode = 2'b00; arm = 1'b1;
    for (int k = 0; k < 3; k++) begin
      trigger_level = (k == 0) ? 16'hFFFF : (k == 1) ? 16'h4000 : 16'h3FFF;
      cnt = 0; seen = 0;
      for (int i = 0; i < 40; i++) begin
        adc_dat_a = ((i / 4) % 2 == 1) ? 16'h8000 : 16'h0000;
        adc_dat_b = adc_dat_a;
        tick();
        if (m_axis_tvalid) begin
          cnt++;
          if (!seen) begin
            seen = 1;
            total++; if (m_axis_tdata !== 16'h4000) $display("FAIL level_3fff_data got=%h want=4000", m_axis_tdata); else passed++;
          end
        end
      end
      total++; if ((cnt != 0) !== (k == 2)) $display("FAIL level_%h valid_cycles got=%0d want_trigger=%b", trigger_level, cnt, k == 2); else passed++;
    end
  endtask

  task automatic test_random();
    int v;
    settle();
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) trigger_level = 16'($urandom_range(0, 60));
      v = int'($urandom_range(0, 80)) - 40; adc_dat_a = 16'(v * 4);
      v = int'($urandom_range(0, 80)) - 40; adc_dat_b = 16'(v * 4);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      arm           = ($urandom_range(0, 19) != 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      aresetn       = ($urandom_range(0, 199) != 0);
      tick();
      total++; if (m_axis_tvalid !== m_v) $display("FAIL rnd_tvalid cyc=%0d got=%b want=%b", i, m_axis_tvalid, m_v); else passed++;
      total++; if (m_axis_tlast !== m_l) $display("FAIL rnd_tlast cyc=%0d got=%b want=%b", i, m_axis_tlast, m_l); else passed++;
      total++; if (triggered !== m_burst) $display("FAIL rnd_triggered cyc=%0d got=%b want=%b", i, triggered, m_burst); else passed++;
      total++; if (overrun !== m_ovr) $display("FAIL rnd_overrun cyc=%0d got=%b want=%b", i, overrun, m_ovr); else passed++;
      if (m_v) begin
        total++; if (m_axis_tdata !== 16'(m_d)) $display("FAIL rnd_tdata cyc=%0d got=%0d want=%0d", i, m_axis_tdata, m_d); else passed++;
      end
    end
    aresetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_metric();
    test_burst();
    test_backpressure();
    test_reset_mid_burst();
    test_armed_above();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_trigger.md
ADC_TRIGGER -- requirements
Module: adc_trigger

Interface
REQ-001 SHALL have parameter ADC_DATA_WIDTH, default 14, range 8..15: significant sample bits, taken as MSBs of each 16-bit ADC input.
REQ-002 SHALL have parameter POST_SAMPLES, default 1024, range 2..65535: beats emitted per trigger.
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 256, range 1..65535: dead time after a burst.
REQ-004 SHALL have port aclk, input, 1: sole clock, all logic on rising edge.
REQ-005 SHALL have port aresetn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port adc_csn, output, 1: ADC chip select, constant 1.
REQ-007 SHALL have ports adc_dat_a and adc_dat_b, input, 16 each: raw ADC words.
REQ-008 SHALL have port mode, input, 2: metric select.
REQ-009 SHALL have port trigger_level, input, 16: unsigned threshold.
REQ-010 SHALL have port arm, input, 1: enables triggering.
REQ-011 SHALL have port triggered, output, 1: high in CAPTURE state.
REQ-012 SHALL have port overrun, output, 1: sticky sample-loss flag.
REQ-013 SHALL have ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tdata (out, 16), m_axis_tlast (out, 1): AXI4-Stream master.

Function
REQ-014 SHALL interpret adc_dat_x[15:16-ADC_DATA_WIDTH] as two's-complement samples.
REQ-015 SHALL compute abs per channel as ADC_DATA_WIDTH-bit unsigned; most-negative input yields 2^(ADC_DATA_WIDTH-1), no saturation.
REQ-016 SHALL form metric: mode 00 = absA+absB (ADC_DATA_WIDTH+1 bits); 01 = max(absA,absB); 10 = absA; 11 = absB; zero-extended to 16 bits.
REQ-017 SHALL pipeline capture -> abs -> metric as three registered stages; metric reflects inputs sampled 3 edges earlier; mode changes take effect on the metric stage.
REQ-018 SHALL implement FSM states IDLE, ARMED, CAPTURE, HOLDOFF.
REQ-019 IDLE -> ARMED when arm=1; ARMED -> IDLE when arm=0.
REQ-020 ARMED -> CAPTURE on rising crossing only: current metric > trigger_level and previous-cycle metric <= trigger_level; a metric already above level on entry to ARMED SHALL NOT trigger.
REQ-021 In CAPTURE the crossing sample SHALL be beat 0; each subsequent metric sample SHALL be loaded into the output register when it is empty or accepted in that cycle.
REQ-022 Output beat SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0; samples arriving then are discarded and overrun set to 1.
REQ-023 Only accepted beats (tvalid&tready) SHALL advance the beat counter; m_axis_tlast=1 exactly on beat POST_SAMPLES-1.
REQ-024 On acceptance of the tlast beat: CAPTURE -> HOLDOFF, tvalid low next cycle.
REQ-025 HOLDOFF SHALL last HOLDOFF_CYCLES cycles, then -> ARMED if arm=1 else IDLE.
REQ-026 Deasserting arm during CAPTURE or HOLDOFF SHALL NOT abort the burst or holdoff.
REQ-027 overrun SHALL clear only on reset or on IDLE -> ARMED transition.
REQ-028 trigger_level SHALL be compared unsigned, full 16 bits; 0xFFFF never triggers.

Reset
REQ-029 On aresetn=0 at a rising edge: state IDLE, pipeline and counters 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, triggered=0, overrun=0, regardless of state (incl. mid-burst).
REQ-030 First capture possible no earlier than 4 edges after aresetn returns high with arm=1.

Verification (ADC_DATA_WIDTH=14, POST_SAMPLES=4, HOLDOFF_CYCLES=8)
REQ-031 mode 00, a=0xFFFC, b=0x0028 -> metric 11 (abs 1 + abs 10) 3 edges later.
REQ-032 a=0x8000 (-8192), mode 10 -> metric 0x2000; mode 00 with b=0x8000 -> 0x4000.
REQ-033 arm=1, level=100, metric 50 then 200 constant, tready=1 -> 4 beats of 200, tlast on 4th, 8 idle cycles, no retrigger while metric stays 200.
REQ-034 As REQ-033 but tready=0 for 3 cycles after beat 1 -> beat 1 held stable, overrun=1, exactly 4 beats still delivered.
REQ-035 aresetn=0 during beat 2 -> next edge tvalid=0, triggered=0, overrun=0, state IDLE.
REQ-036 Metric 200 already above level when arm rises -> no trigger until metric drops <=100 and rises again.
